// File: rtl/turn_hit_ctrl_if.sv
// turn_hit_ctrl_if: game-flow bus between input decode, projectile logic and draw stages
interface turn_hit_ctrl_if #(
    parameter int HP_MAX = 5
);
    localparam int HW = $clog2(HP_MAX + 1);
    logic start;
    logic launch;
    logic impact_hit;
    logic impact_miss;
    logic turn_cat;
    logic turn_dog;
    logic throw_cat;
    logic throw_dog;
    logic flash_cat;
    logic flash_dog;
    logic [HW-1:0] hp_cat;
    logic [HW-1:0] hp_dog;
    logic game_over;
    logic winner_dog;
    modport master (
        output start, launch, impact_hit, impact_miss,
        input  turn_cat, turn_dog, throw_cat, throw_dog, flash_cat, flash_dog,
        input  hp_cat, hp_dog, game_over, winner_dog
    );
    modport slave (
        input  start, launch, impact_hit, impact_miss,
        output turn_cat, turn_dog, throw_cat, throw_dog, flash_cat, flash_dog,
        output hp_cat, hp_dog, game_over, winner_dog
    );
endinterface

// File: rtl/turn_hit_ctrl.sv
// turn_hit_ctrl: Cat vs Dog turn/hit controller; optional flight watchdog via FLIGHT_TIMEOUT_EN
module turn_hit_ctrl #(
    parameter int FLASH_TICKS   = 32_500_000,
    parameter int HP_MAX        = 5,
    parameter int TIMEOUT_TICKS = 195_000_000
) (
    input logic clk,
    input logic rst,
    turn_hit_ctrl_if.slave bus
);
    localparam int HW  = $clog2(HP_MAX + 1);
    localparam int FW  = $clog2(FLASH_TICKS);
    localparam int TW  = $clog2(TIMEOUT_TICKS);
    localparam int CW0 = FW > TW ? FW : TW;
    localparam int CW  = CW0 < 1 ? 1 : CW0;
`ifdef FLIGHT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, AIM_CAT, FLIGHT_CAT, AIM_DOG, FLIGHT_DOG, FLASH, OVER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          next_dog;
    logic          tmo;

    // flight watchdog expiry; an impact in the same cycle is handled first
    assign tmo = TMO_EN && (cnt == CW'(TIMEOUT_TICKS - 1));

    // game FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            next_dog       <= 1'b0;
            bus.turn_cat   <= 1'b0;
            bus.turn_dog   <= 1'b0;
            bus.throw_cat  <= 1'b0;
            bus.throw_dog  <= 1'b0;
            bus.flash_cat  <= 1'b0;
            bus.flash_dog  <= 1'b0;
            bus.hp_cat     <= HW'(HP_MAX);
            bus.hp_dog     <= HW'(HP_MAX);
            bus.game_over  <= 1'b0;
            bus.winner_dog <= 1'b0;
        end else begin
            bus.throw_cat <= 1'b0;
            bus.throw_dog <= 1'b0;
            case (state)
                IDLE, OVER: if (bus.start) begin
                    bus.hp_cat    <= HW'(HP_MAX);
                    bus.hp_dog    <= HW'(HP_MAX);
                    bus.game_over <= 1'b0;
                    bus.turn_cat  <= 1'b1;
                    state         <= AIM_CAT;
                end
                AIM_CAT: if (bus.launch) begin
                    bus.throw_cat <= 1'b1;
                    cnt           <= '0;
                    state         <= FLIGHT_CAT;
                end
                AIM_DOG: if (bus.launch) begin
                    bus.throw_dog <= 1'b1;
                    cnt           <= '0;
                    state         <= FLIGHT_DOG;
                end
                FLIGHT_CAT: begin
                    if (bus.impact_hit) begin
                        bus.hp_dog    <= bus.hp_dog == '0 ? '0 : bus.hp_dog - 1'b1;
                        bus.flash_dog <= 1'b1;
                        bus.turn_cat  <= 1'b0;
                        cnt           <= '0;
                        next_dog      <= 1'b1;
                        state         <= FLASH;
                    end else if (bus.impact_miss || tmo) begin
                        bus.turn_cat <= 1'b0;
                        bus.turn_dog <= 1'b1;
                        state        <= AIM_DOG;
                    end else begin
                        cnt <= cnt + CW'(TMO_EN);
                    end
                end
                FLIGHT_DOG: begin
                    if (bus.impact_hit) begin
                        bus.hp_cat    <= bus.hp_cat == '0 ? '0 : bus.hp_cat - 1'b1;
                        bus.flash_cat <= 1'b1;
                        bus.turn_dog  <= 1'b0;
                        cnt           <= '0;
                        next_dog      <= 1'b0;
                        state         <= FLASH;
                    end else if (bus.impact_miss || tmo) begin
                        bus.turn_dog <= 1'b0;
                        bus.turn_cat <= 1'b1;
                        state        <= AIM_CAT;
                    end else begin
                        cnt <= cnt + CW'(TMO_EN);
                    end
                end
                FLASH: begin
                    if (cnt == CW'(FLASH_TICKS - 1)) begin
                        bus.flash_cat <= 1'b0;
                        bus.flash_dog <= 1'b0;
                        cnt           <= '0;
                        if ((next_dog ? bus.hp_dog : bus.hp_cat) == '0) begin
                            bus.game_over  <= 1'b1;
                            bus.winner_dog <= !next_dog;
                            state          <= OVER;
                        end else begin
                            bus.turn_dog <= next_dog;
                            bus.turn_cat <= !next_dog;
                            state        <= next_dog ? AIM_DOG : AIM_CAT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/turn_hit_ctrl.md
Name: turn_hit_ctrl

Overview:
- Game-flow controller for Cat vs Dog: decides whose turn it is, starts throws, and applies projectile impacts.
- Keeps both players' hit points and generates the per-player flash-active signals that the cat and dog draw stages consume.
- Sits between input decoding, the projectile/collision logic and the player draw stages; clocked by the 65 MHz pixel clock.

Parameters:
- FLASH_TICKS, 32_500_000, length of the post-hit flash in clk cycles (0.5 s at 65 MHz); must be >= 1.
- HP_MAX, 5, starting hit points per player; must be >= 1.
- TIMEOUT_TICKS, 195_000_000, flight watchdog limit in clk cycles (3 s); used only with FLIGHT_TIMEOUT_EN.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; starts a new game
- launch  in  1  one-cycle pulse; the active player throws
- impact_hit  in  1  one-cycle pulse; projectile struck the opponent
- impact_miss  in  1  one-cycle pulse; projectile landed without a hit
- turn_cat  out  1  high during cat aim and cat flight
- turn_dog  out  1  high during dog aim and dog flight
- throw_cat  out  1  one-cycle pulse; starts the cat projectile
- throw_dog  out  1  one-cycle pulse; starts the dog projectile
- flash_cat  out  1  cat flash active
- flash_dog  out  1  dog flash active
- hp_cat  out  $clog2(HP_MAX+1)  cat hit points
- hp_dog  out  $clog2(HP_MAX+1)  dog hit points
- game_over  out  1  a game has ended
- winner_dog  out  1  valid while game_over: 1 = dog won, 0 = cat won

Behaviour:
- Reset values: state IDLE; every output 0; both hp at HP_MAX; flash counter 0.
- All outputs are registered. Every transition takes effect on the clk edge that samples its cause, so outputs change 1 cycle after the input pulse.
- FSM states: IDLE, AIM_CAT, FLIGHT_CAT, AIM_DOG, FLIGHT_DOG, FLASH, OVER.
- IDLE: on start, load hp_cat = hp_dog = HP_MAX and go to AIM_CAT.
- AIM_CAT: on launch, emit throw_cat for 1 cycle and go to FLIGHT_CAT. AIM_DOG does the same with throw_dog and FLIGHT_DOG.
- FLIGHT_x on impact_hit:
  - decrement the opponent's hp, saturating at 0;
  - go to FLASH and assert the opponent's flash;
  - clear the counter and latch next_turn = opponent.
- FLIGHT_x on impact_miss (no hit): go to AIM of the opponent.
- impact_hit and impact_miss in the same cycle: the hit wins.
- FLASH:
  - counter increments each cycle; flash_x stays high for exactly FLASH_TICKS cycles;
  - when counter == FLASH_TICKS-1: clear flash and counter;
  - if the hit player's hp == 0, go to OVER with winner_dog = (hit player was cat); otherwise go to AIM of next_turn.
- The hit player takes the next turn, so turns alternate.
- OVER: game_over = 1 and turn outputs 0. On start, reload hp, clear game_over, go to AIM_CAT.
- Ignored inputs:
  - launch outside AIM states;
  - impact pulses outside FLIGHT states, including during FLASH (no double damage);
  - start outside IDLE and OVER.
- turn_cat and turn_dog are never both 1. flash_cat and flash_dog are never both 1.
- Counter width is $clog2(FLASH_TICKS) (or the TIMEOUT_TICKS width, whichever is larger); no wrap-around is possible.
- rst asserted mid-game: immediate return to reset values, including in-progress flash and pending throws.

Optional Feature:
- Macro: FLIGHT_TIMEOUT_EN.
- Defined:
  - a shared counter runs during FLIGHT states, cleared on entry;
  - if no impact arrives within TIMEOUT_TICKS cycles, treat it as impact_miss (go to AIM of the opponent);
  - an impact on the final cycle takes priority over the timeout.
- Not defined: FLIGHT states wait indefinitely for an impact; TIMEOUT_TICKS is unused.

Test Plan:
- (FLASH_TICKS=8, HP_MAX=2 throughout.) Reset, then start -> next cycle turn_cat=1, hp_cat=hp_dog=2, all other outputs 0.
- launch in AIM_CAT -> throw_cat high exactly 1 cycle, turn_cat stays 1; then impact_miss -> turn_dog=1, hp unchanged.
- Cat flight, impact_hit -> hp_dog=1, flash_dog high exactly 8 cycles with turn outputs 0, then turn_dog=1; impact_hit pulses during the flash leave hp_dog=1.
- Two dog hits -> after the second flash: game_over=1, winner_dog=0, hp_dog=0; launch ignored; start -> hp back to 2, turn_cat=1.
- impact_hit and impact_miss in the same cycle during FLIGHT_DOG -> hp_cat decremented and flash_cat asserted; launch in IDLE -> no throw pulse.
- rst asserted on the 4th flash cycle -> flash_dog=0 and hp=2 at once, state IDLE. With FLIGHT_TIMEOUT_EN and TIMEOUT_TICKS=16: no impact for 16 cycles -> turn switches to the opponent.
